vec_list_sequencer: RTL and testbench

- Walks one vector shape stored in the vector-list ROM and streams its points to the vector draw engine over a valid/ready handshake.
- Each ROM entry is {x, y, line, pos}. The shape starts at a per-shape base address and ends at the end marker (line=1, pos=1).
- Applies a per-object saturating X/Y translation so that one ROM shape (bomber, cursor) can be drawn at any screen position.
- Adds an abort input and a runaway-length guard.

---
 rtl/vec_pkg.sv | 32 +++
 rtl/vec_list_sequencer_if.sv | 33 +++
 rtl/vec_sat_add.sv | 20 ++
 rtl/vec_list_sequencer.sv | 170 +++++++++++++++++
 tb/tb_vec_list_sequencer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_pkg.sv
// Shared types for the vector-list sequencer: ROM entry layout, FSM states, end-marker test.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package vec_pkg;

  // Coordinate width of the canonical ROM word layout
  localparam int VEC_CW = 8;

  // A shape is terminated by an entry with both flag bits set
  localparam logic END_LINE = 1'b1;
  localparam logic END_POS  = 1'b1;

  typedef struct packed {
    logic [VEC_CW-1:0] x;
    logic [VEC_CW-1:0] y;
    logic              line;
    logic              pos;
  } vec_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EMIT,
    DONE,
    ERR
  } seq_state_t;

  function automatic logic is_end_marker(input logic line, input logic pos);
    return (line == END_LINE) && (pos == END_POS);
  endfunction

endpackage

// File: rtl/vec_list_sequencer_if.sv
// Point stream from the sequencer to the vector draw engine.
// Latency: n/a (wires only).
// Backpressure: valid/ready; a point moves when both are high on a clock edge.
interface vec_list_sequencer_if #(
  parameter int COORDWIDTH = 8
);

  logic                  vec_valid;
  logic                  vec_ready;
  logic [COORDWIDTH-1:0] vec_x;
  logic [COORDWIDTH-1:0] vec_y;
  logic                  vec_line;
  logic                  vec_clip;

  modport master (
    output vec_valid,
    output vec_x,
    output vec_y,
    output vec_line,
    output vec_clip,
    input  vec_ready
  );

  modport slave (
    input  vec_valid,
    input  vec_x,
    input  vec_y,
    input  vec_line,
    input  vec_clip,
    output vec_ready
  );

endinterface

// File: rtl/vec_sat_add.sv
// Unsigned adder that clamps to all-ones on overflow and flags the clamp.
// Latency: combinational.
// Backpressure: n/a.
module vec_sat_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         clip
);

  // One extra bit holds the carry that signals overflow
  logic [W:0] raw;

  assign raw  = {1'b0, a} + {1'b0, b};
  assign clip = raw[W];
  assign sum  = clip ? {W{1'b1}} : raw[W-1:0];

endmodule

// File: rtl/vec_list_sequencer.sv
// Walks one ROM vector shape from its base address to the end marker and streams translated points.
// Latency: first point valid 2 cycles after start; at most one point every 2 cycles (no prefetch).
// Backpressure: a point is held stable with the ROM address frozen until vec_ready; abort overrides ready.
module vec_list_sequencer
  import vec_pkg::*;
#(
  parameter int ADDRESSWIDTH = 16,
  parameter int COORDWIDTH   = 8,
  parameter int NUM_SHAPES   = 4,
  parameter int MAX_LEN      = 64,
  localparam int SELW        = (NUM_SHAPES > 1) ? $clog2(NUM_SHAPES) : 1,
  localparam int CNTW        = $clog2(MAX_LEN + 1),
  localparam int ROMW        = 2 * COORDWIDTH + 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [SELW-1:0]                    shape_sel,
  input  logic [NUM_SHAPES*ADDRESSWIDTH-1:0] shape_base,
  input  logic [COORDWIDTH-1:0]              off_x,
  input  logic [COORDWIDTH-1:0]              off_y,
  input  logic                               abort,
  output logic [ADDRESSWIDTH-1:0]            rom_addr,
  input  logic [ROMW-1:0]                    rom_data,
  vec_list_sequencer_if.master               vec,
  output logic                               busy,
  output logic                               done,
  output logic                               error
);

  seq_state_t state_q;
  seq_state_t state_d;

  logic [CNTW-1:0]         cnt_q;
  logic [CNTW-1:0]         cnt_inc;
  logic [COORDWIDTH-1:0]   offx_q;
  logic [COORDWIDTH-1:0]   offy_q;

  logic [COORDWIDTH-1:0]   ent_x;
  logic [COORDWIDTH-1:0]   ent_y;
  logic                    ent_line;
  logic                    ent_pos;

  logic [COORDWIDTH-1:0]   sum_x;
  logic [COORDWIDTH-1:0]   sum_y;
  logic                    clip_x;
  logic                    clip_y;

  logic                    accept;
  logic                    emit;
  logic                    advance;

  logic [ADDRESSWIDTH-1:0] base_tbl [NUM_SHAPES];

  for (genvar g = 0; g < NUM_SHAPES; g++) begin : g_base
    assign base_tbl[g] = shape_base[g*ADDRESSWIDTH +: ADDRESSWIDTH];
  end

  assign {ent_x, ent_y, ent_line, ent_pos} = rom_data;
  assign cnt_inc = cnt_q + CNTW'(1);

  vec_sat_add #(.W(COORDWIDTH)) u_add_x (
    .a    (ent_x),
    .b    (offx_q),
    .sum  (sum_x),
    .clip (clip_x)
  );

  vec_sat_add #(.W(COORDWIDTH)) u_add_y (
    .a    (ent_y),
    .b    (offy_q),
    .sum  (sum_y),
    .clip (clip_y)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; abort outranks the end marker, the length guard and vec_ready
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    emit    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          accept  = 1'b1;
        end
      end
      FETCH: begin
        if (abort) begin
          state_d = ERR;
        end else if (is_end_marker(ent_line, ent_pos)) begin
          state_d = DONE;
        end else if (cnt_inc == CNTW'(MAX_LEN)) begin
          state_d = ERR;
        end else begin
          state_d = EMIT;
          emit    = 1'b1;
        end
      end
      EMIT: begin
        if (abort) begin
          state_d = ERR;
        end else if (vec.vec_ready) begin
          state_d = FETCH;
          advance = 1'b1;
        end
      end
      DONE: begin
        state_d = abort ? ERR : IDLE;
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address walk, entry count, captured offsets and the registered output point
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr      <= '0;
      cnt_q         <= '0;
      offx_q        <= '0;
      offy_q        <= '0;
      vec.vec_valid <= 1'b0;
      vec.vec_x     <= '0;
      vec.vec_y     <= '0;
      vec.vec_line  <= 1'b0;
      vec.vec_clip  <= 1'b0;
    end else begin
      // EMIT is only ever entered with a freshly registered point
      vec.vec_valid <= (state_d == EMIT);
      if (accept) begin
        rom_addr <= base_tbl[shape_sel];
        cnt_q    <= '0;
        offx_q   <= off_x;
        offy_q   <= off_y;
      end
      if (state_q == FETCH) begin
        cnt_q <= cnt_inc;
      end
      if (emit) begin
        vec.vec_x    <= sum_x;
        vec.vec_y    <= sum_y;
        vec.vec_line <= ent_line;
        vec.vec_clip <= clip_x | clip_y;
      end
      if (advance) begin
        rom_addr <= rom_addr + ADDRESSWIDTH'(1);
      end
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign error = (state_q == ERR);

endmodule

// File: tb/tb_vec_list_sequencer.sv
module tb_vec_list_sequencer;
  import vec_pkg::*;

  localparam int AW   = 16;
  localparam int CW   = 8;
  localparam int NS   = 4;
  localparam int MAXL = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [1:0]       shape_sel = '0;
  logic [NS*AW-1:0] shape_base;
  logic [CW-1:0]    off_x = '0;
  logic [CW-1:0]    off_y = '0;
  logic [AW-1:0]    rom_addr;
  logic [2*CW+1:0]  rom_data;
  logic             busy;
  logic             done;
  logic             error;

  vec_entry_t rom [0:65535];

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q [$];
  logic [17:0] obs_q [$];
  logic        exp_done;

  vec_list_sequencer_if #(.COORDWIDTH(CW)) vif ();

  vec_list_sequencer #(
    .ADDRESSWIDTH (AW),
    .COORDWIDTH   (CW),
    .NUM_SHAPES   (NS),
    .MAX_LEN      (MAXL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .shape_sel  (shape_sel),
    .shape_base (shape_base),
    .off_x      (off_x),
    .off_y      (off_y),
    .abort      (abort),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .vec        (vif),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // The registered rom_addr acts as the ROM's address register: data is valid the cycle after it updates
  assign rom_data = rom[rom_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic vec_entry_t mk(input int x, input int y, input logic l, input logic p);
    vec_entry_t e;
    e.x = 8'(x);
    e.y = 8'(y);
    e.line = l;
    e.pos = p;
    return e;
  endfunction

  function automatic logic [17:0] pk(input int x, input int y, input logic l, input logic c);
    return {8'(x), 8'(y), l, c};
  endfunction

  function automatic logic [17:0] cur_pt();
    return pk(int'(vif.vec_x), int'(vif.vec_y), vif.vec_line, vif.vec_clip);
  endfunction

  function automatic logic [17:0] obs_at(input int i);
    return (i < obs_q.size()) ? obs_q[i] : 18'h3ffff;
  endfunction

  function automatic logic [63:0] outs();
    return {rom_addr, vif.vec_valid, vif.vec_x, vif.vec_y, vif.vec_line, vif.vec_clip, busy, done, error};
  endfunction

  // Reference: walk the shape entry by entry, stop at the marker or once MAX_LEN entries were read
  task automatic model(input logic [AW-1:0] base, input int ox, input int oy);
    vec_entry_t e;
    int sx, sy;
    exp_q.delete();
    exp_done = 1'b0;
    for (int i = 0; i < MAXL; i++) begin
      e = rom[16'(int'(base) + i)];
      if (e.line && e.pos) begin
        exp_done = 1'b1;
        return;
      end
      if (i + 1 == MAXL) return;
      sx = int'(e.x) + ox;
      sy = int'(e.y) + oy;
      exp_q.push_back(pk((sx > 255) ? 255 : sx, (sy > 255) ? 255 : sy, e.line, (sx > 255) || (sy > 255)));
    end
  endtask

  task automatic run_shape(input logic [1:0] sel, input int ox, input int oy, input int rdy_pct, input bit stall2);
    int n;
    int stalls;
    bit fin;
    bit hold;
    logic [63:0] held;
    logic [AW-1:0] base;
    base = shape_base[sel*AW +: AW];
    model(base, ox, oy);
    obs_q.delete();
    @(negedge clk);
    start = 1'b1;
    shape_sel = sel;
    off_x = 8'(ox);
    off_y = 8'(oy);
    @(negedge clk);
    start = 1'b0;
    off_x = 8'($urandom);
    off_y = 8'($urandom);
    shape_sel = 2'($urandom);
    chk("busy_on", busy, 1);
    n = 0;
    stalls = 0;
    fin = 0;
    hold = 0;
    held = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (done || error) begin
        start = 1'b0;
        chk("end", {done, error}, exp_done ? 2'b10 : 2'b01);
        chk("npts", n, exp_q.size());
        if (rdy_pct == 100 && !stall2) chk("lat", cyc, 2 * exp_q.size() + 1);
        if (stall2) chk("stalls", stalls, 5);
        fin = 1;
        break;
      end
      if (hold) chk("hold", {vif.vec_valid, cur_pt(), rom_addr}, held);
      vif.vec_ready = ($urandom_range(99) < rdy_pct);
      if (stall2 && n == 1 && vif.vec_valid && stalls < 5) begin
        vif.vec_ready = 1'b0;
        stalls++;
      end
      // Stray starts while busy must be ignored, including their shape_sel
      start = ($urandom_range(3) == 0);
      shape_sel = 2'($urandom);
      if (vif.vec_valid && vif.vec_ready) begin
        obs_q.push_back(cur_pt());
        if (n < exp_q.size()) chk("pt", cur_pt(), exp_q[n]);
        else chk("extra_pt", n, exp_q.size());
        n++;
      end
      hold = vif.vec_valid && !vif.vec_ready;
      held = {1'b1, cur_pt(), rom_addr};
      @(negedge clk);
    end
    if (!fin) begin
      start = 1'b0;
      chk("timeout", 0, 1);
    end
    vif.vec_ready = 1'b0;
    @(negedge clk);
    chk("idle_after", {busy, done, error}, 0);
  endtask

  initial begin
    logic [AW-1:0] base;
    int len;
    int nv;
    bit found;
    vec_entry_t e;

    for (int i = 0; i < 65536; i++) rom[i] = '0;
    // Frame shape
    rom[42] = mk(0, 255, 1'b0, 1'b1);
    rom[43] = mk(0, 0, 1'b1, 1'b0);
    rom[44] = mk(255, 0, 1'b1, 1'b0);
    rom[45] = mk(255, 255, 1'b1, 1'b0);
    rom[46] = mk(0, 255, 1'b1, 1'b0);
    rom[47] = mk(0, 0, 1'b1, 1'b1);
    // Cursor shape
    rom[48] = mk(22, 50, 1'b0, 1'b1);
    rom[49] = mk(46, 46, 1'b1, 1'b0);
    rom[50] = mk(30, 60, 1'b1, 1'b0);
    rom[51] = mk(0, 0, 1'b1, 1'b1);
    // Runaway region without a marker
    for (int i = 0; i < 16; i++) rom[100 + i] = mk(i * 10, i * 3, 1'(i), 1'b0);
    shape_base = {16'd2000, 16'd100, 16'd48, 16'd42};
    vif.vec_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_hold", outs(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out", outs(), 0);

    run_shape(2'd0, 0, 0, 100, 1'b0);
    chk("frame_p0", obs_at(0), pk(0, 255, 0, 0));
    chk("frame_p4", obs_at(4), pk(0, 255, 1, 0));

    run_shape(2'd1, 220, 10, 100, 1'b0);
    chk("cur_p0", obs_at(0), pk(242, 60, 0, 0));
    chk("cur_p1", obs_at(1), pk(255, 56, 1, 1));

    run_shape(2'd0, 5, 7, 100, 1'b1);

    run_shape(2'd2, 0, 0, 100, 1'b0);
    chk("runaway_n", obs_q.size(), 7);

    // Abort together with a live handshake on the second point
    @(negedge clk);
    start = 1'b1;
    shape_sel = 2'd0;
    off_x = '0;
    off_y = '0;
    vif.vec_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nv = 0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (vif.vec_valid) begin
        nv++;
        if (nv == 2) begin
          abort = 1'b1;
          found = 1;
          break;
        end
      end
      @(negedge clk);
    end
    chk("ab_found", found, 1);
    @(negedge clk);
    abort = 1'b0;
    chk("ab_err", {rom_addr, vif.vec_valid, done, error}, {16'd43, 3'b001});
    @(negedge clk);
    chk("ab_idle", {busy, done, error, vif.vec_valid}, 0);
    vif.vec_ready = 1'b0;

    // Abort while idle does nothing
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    chk("ab_in_idle", {busy, done, error}, 0);

    // Reset in the middle of a held point, then replay from the base
    start = 1'b1;
    shape_sel = 2'd1;
    off_x = 8'd3;
    off_y = 8'd4;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (vif.vec_valid) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rm_found", found, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid", outs(), 0);
    run_shape(2'd1, 200, 100, 70, 1'b0);
    chk("replay_p0", obs_at(0), pk(222, 150, 0, 0));

    // Random shapes: length 1..10 (marker at len-1), random base incl. address wrap, random offsets and stalls
    for (int t = 0; t < 20; t++) begin
      base = ($urandom_range(3) == 0) ? 16'(16'hffff - $urandom_range(3)) : 16'($urandom_range(1000, 60000));
      len = $urandom_range(1, 10);
      for (int i = 0; i < 10; i++) begin
        e = mk($urandom_range(255), $urandom_range(255), 1'($urandom), 1'($urandom));
        if (e.line && e.pos) e.pos = 1'b0;
        if (i == len - 1) e = mk($urandom_range(255), $urandom_range(255), 1'b1, 1'b1);
        rom[16'(int'(base) + i)] = e;
      end
      shape_base[3*AW +: AW] = base;
      run_shape(2'd3, $urandom_range(255), $urandom_range(255), $urandom_range(30, 100), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
